// File: rtl/fq_timed_buffer_pkg.sv
// Shared constants for the flow-queue timed buffer and other time-aware stages.
// Timestamps are modular and wrap at 2^FQ_TS_WIDTH.
package fq_timed_buffer_pkg;

   localparam int unsigned FQ_DATA_WIDTH = 36;
   localparam int unsigned FQ_TS_WIDTH   = 10;
   localparam int unsigned FQ_LOG_DEPTH  = 3;

endpackage

// File: rtl/fq_timed_buffer_if.sv
// Flit-in / flit-out handshake bundle of the timed buffer, plus status signals.
// The slave modport is the buffer side; the master modport is the upstream/downstream side.
interface fq_timed_buffer_if
   import fq_timed_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FQ_DATA_WIDTH,
   parameter int unsigned TS_WIDTH   = FQ_TS_WIDTH,
   parameter int unsigned LOG_DEPTH  = FQ_LOG_DEPTH
) ();

   logic [TS_WIDTH-1:0]   sim_time;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic [TS_WIDTH-1:0]   in_timestamp;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [TS_WIDTH-1:0]   out_timestamp;
   logic                  out_ready;
   logic [LOG_DEPTH:0]    occupancy;
   logic                  order_err;

   modport slave (
      input  sim_time, in_valid, in_data, in_timestamp, out_ready,
      output in_ready, out_valid, out_data, out_timestamp, occupancy, order_err
   );

   modport master (
      output sim_time, in_valid, in_data, in_timestamp, out_ready,
      input  in_ready, out_valid, out_data, out_timestamp, occupancy, order_err
   );

endinterface

// File: rtl/fq_timed_buffer_ts_le_wrap.sv
// Combinational wrap-safe "a <= b" for modular timestamps: true when b is at most
// half the timestamp range ahead of (or equal to) a.
module fq_timed_buffer_ts_le_wrap
   import fq_timed_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = FQ_TS_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             le
);

   logic [WIDTH-1:0] diff;

   always_comb begin
      diff = b - a;
      le   = ~diff[WIDTH-1];
   end

endmodule

// File: rtl/fq_timed_buffer.sv
// Per-flow-queue FIFO of timestamped flits; the head is released only once sim_time
// has reached its departure timestamp. Strict FIFO order, no bypass path.
module fq_timed_buffer
   import fq_timed_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FQ_DATA_WIDTH,
   parameter int unsigned TS_WIDTH   = FQ_TS_WIDTH,
   parameter int unsigned LOG_DEPTH  = FQ_LOG_DEPTH
) (
   input logic              clock,
   input logic              reset,
   fq_timed_buffer_if.slave bus
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;

   typedef logic [LOG_DEPTH-1:0] ptr_t;
   typedef logic [LOG_DEPTH:0]   cnt_t;

   localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

   logic [TS_WIDTH-1:0]   ts_q   [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   ptr_t                  wr_ptr_q;
   ptr_t                  rd_ptr_q;
   cnt_t                  count_q;
   logic [TS_WIDTH-1:0]   last_ts_q;
   logic                  last_vld_q;
   logic                  order_err_q;

   logic                  in_ready;
   logic                  out_valid;
   logic                  push;
   logic                  pop;
   logic                  due;
   logic                  in_le_last;
   logic                  order_bad;
   logic [TS_WIDTH-1:0]   head_ts;

   assign head_ts = ts_q[rd_ptr_q];

   fq_timed_buffer_ts_le_wrap #(
      .WIDTH (TS_WIDTH)
   ) u_due_cmp (
      .a  (head_ts),
      .b  (bus.sim_time),
      .le (due)
   );

   fq_timed_buffer_ts_le_wrap #(
      .WIDTH (TS_WIDTH)
   ) u_order_cmp (
      .a  (bus.in_timestamp),
      .b  (last_ts_q),
      .le (in_le_last)
   );

   always_comb begin
      // Full blocks a push even when a pop frees a slot in the same cycle.
      in_ready  = (count_q != FULL_COUNT);
      out_valid = (count_q != '0) && due;
      push      = bus.in_valid && in_ready;
      pop       = out_valid && bus.out_ready;
      order_bad = last_vld_q && in_le_last && (bus.in_timestamp != last_ts_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ts_q        <= '{default: '0};
         data_q      <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_ts_q   <= '0;
         last_vld_q  <= 1'b0;
         order_err_q <= 1'b0;
      end else begin
         if (push) begin
            ts_q[wr_ptr_q]   <= bus.in_timestamp;
            data_q[wr_ptr_q] <= bus.in_data;
            wr_ptr_q         <= wr_ptr_q + ptr_t'(1);
            last_ts_q        <= bus.in_timestamp;
            last_vld_q       <= 1'b1;
            if (order_bad) begin
               order_err_q <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + ptr_t'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + cnt_t'(1);
            2'b01:   count_q <= count_q - cnt_t'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid;
   assign bus.out_data      = data_q[rd_ptr_q];
   assign bus.out_timestamp = head_ts;
   assign bus.occupancy     = count_q;
   assign bus.order_err     = order_err_q;

endmodule

// File: tb/tb_fq_timed_buffer.sv
// Bench for fq_timed_buffer: per-cycle vectors with hand-derived expectations and a
// payload scoreboard that checks FIFO order of everything the DUT releases.
module tb_fq_timed_buffer;

   logic clock;
   logic reset;

   fq_timed_buffer_if bus ();

   fq_timed_buffer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       iv;
      logic [9:0] ts;
      logic       ordy;
      logic [9:0] st;
      logic       vld;
      logic [3:0] occ;
      logic       rdy;
      logic       oerr;
   } vec_t;

   typedef struct {
      logic [9:0]  ts;
      logic [35:0] data;
   } entry_t;

   entry_t sb[$];
   vec_t   tbl[$];
   int     tests;
   int     fails;

   function automatic vec_t mk(int iv, int ts, int ordy, int st, int vld, int occ, int rdy,
                               int oerr);
      vec_t v;
      v.iv   = 1'(iv);
      v.ts   = 10'(ts);
      v.ordy = 1'(ordy);
      v.st   = 10'(st);
      v.vld  = 1'(vld);
      v.occ  = 4'(occ);
      v.rdy  = 1'(rdy);
      v.oerr = 1'(oerr);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, check outputs mid-cycle, then commit the scoreboard.
   task automatic apply(input vec_t v);
      logic [35:0] d;
      d = 36'({$urandom(), $urandom()});
      bus.in_valid     = v.iv;
      bus.in_timestamp = v.ts;
      bus.in_data      = d;
      bus.out_ready    = v.ordy;
      bus.sim_time     = v.st;
      @(negedge clock);
      chk("in_ready", 64'(bus.in_ready), 64'(v.rdy));
      chk("occupancy", 64'(bus.occupancy), 64'(v.occ));
      chk("out_valid", 64'(bus.out_valid), 64'(v.vld));
      chk("order_err", 64'(bus.order_err), 64'(v.oerr));
      if (v.vld) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: DUT head expected but model queue empty at %0t", $time);
         end else begin
            chk("out_timestamp", 64'(bus.out_timestamp), 64'(sb[0].ts));
            chk("out_data", 64'(bus.out_data), 64'(sb[0].data));
         end
      end
      @(posedge clock);
      #1;
      if (v.vld && v.ordy && sb.size() != 0) void'(sb.pop_front());
      if (v.iv && v.rdy) sb.push_back('{ts: v.ts, data: d});
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_timestamp = '0;
      bus.out_ready = 1'b0;
      bus.sim_time = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      //            iv  ts ordy  st vld occ rdy oerr
      tbl.push_back(mk(0,  0, 0,    0, 0, 0, 1, 0));   // reset state
      tbl.push_back(mk(1,  5, 0,    0, 0, 0, 1, 0));
      for (int t = 0; t < 5; t++) tbl.push_back(mk(0, 0, 1, t, 0, 1, 1, 0));
      tbl.push_back(mk(0,  0, 1,    5, 1, 1, 1, 0));   // due exactly at ts, pop
      tbl.push_back(mk(0,  0, 0,    6, 0, 0, 1, 0));
      tbl.push_back(mk(1, 20, 1,   10, 0, 0, 1, 0));
      tbl.push_back(mk(1,  3, 1,   10, 0, 1, 1, 0));   // out of order push
      tbl.push_back(mk(0,  0, 1,   10, 0, 2, 1, 1));   // non-due head blocks due entry
      tbl.push_back(mk(0,  0, 1,   20, 1, 2, 1, 1));
      tbl.push_back(mk(0,  0, 1,   20, 1, 1, 1, 1));
      tbl.push_back(mk(0,  0, 0,   20, 0, 0, 1, 1));
      foreach (tbl[i]) apply(tbl[i]);

      // Fill to full; full refuses a push even alongside a pop.
      do_reset();
      for (int k = 1; k <= 8; k++) apply(mk(1, k, 0, 0, 0, k - 1, 1, 0));
      apply(mk(1, 9, 0, 0, 0, 8, 0, 0));
      apply(mk(1, 9, 1, 10, 1, 8, 0, 0));
      for (int k = 2; k <= 8; k++) apply(mk(0, 0, 1, 10, 1, 9 - k, 1, 0));
      apply(mk(0, 0, 0, 10, 0, 0, 1, 0));

      // Timestamp wrap around 1024.
      do_reset();
      apply(mk(1, 1020, 0, 1019, 0, 0, 1, 0));
      apply(mk(1,    2, 1, 1019, 0, 1, 1, 0));
      apply(mk(0,    0, 1, 1020, 1, 2, 1, 0));
      apply(mk(0,    0, 1, 1023, 0, 1, 1, 0));
      apply(mk(0,    0, 1,    0, 0, 1, 1, 0));
      apply(mk(0,    0, 1,    1, 0, 1, 1, 0));
      apply(mk(0,    0, 1,    2, 1, 1, 1, 0));
      apply(mk(0,    0, 1,    3, 0, 0, 1, 0));

      // Steady push+pop at occupancy 4.
      for (int k = 0; k < 4; k++) apply(mk(1, 3 + k, 0, 200, (k != 0) ? 1 : 0, k, 1, 0));
      for (int k = 0; k < 10; k++) apply(mk(1, 7 + k, 1, 200, 1, 4, 1, 0));
      apply(mk(1, 17, 0, 200, 1, 4, 1, 0));
      apply(mk(0,  0, 0, 200, 1, 5, 1, 0));

      // Reset with 5 entries held discards them all.
      do_reset();
      apply(mk(1, 50, 0, 200, 0, 0, 1, 0));
      apply(mk(0,  0, 1, 200, 1, 1, 1, 0));
      apply(mk(0,  0, 0, 200, 0, 0, 1, 0));
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
